// File: rtl/spm_pkg.sv
// Shared types and constants for the serial-parallel multiplier MAC sequencer.
// Holds the FSM encoding, operand widths and saturation bound helpers.
package spm_pkg;

  localparam int OP_W        = 8;
  localparam int PROD_W      = 16;
  localparam int MUL_LAT_DEF = 13;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    ACCUM   = 3'd2,
    RELEASE = 3'd3,
    OUTPUT  = 3'd4
  } state_e;

  function automatic logic signed [32:0] sat_max(input int unsigned w);
    return (33'sd1 <<< (w - 1)) - 33'sd1;
  endfunction

  function automatic logic signed [32:0] sat_min(input int unsigned w);
    return -(33'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/spm_mac_sequencer_if.sv
// Operand stream, multiplier handshake and frame-result bundle.
// slave is the sequencer's view, master the surrounding environment.
interface spm_mac_if #(
  parameter int ACC_W = 24
);
  import spm_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [OP_W-1:0]   in_a;
  logic signed [OP_W-1:0]   in_b;
  logic                     in_last;
  logic                     mul_start;
  logic signed [OP_W-1:0]   mul_a;
  logic signed [OP_W-1:0]   mul_b;
  logic signed [PROD_W-1:0] mul_product;
  logic                     mul_done;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_sum;
  logic                     out_sat;
  logic                     err_timeout;

  modport slave (
    input  in_valid, in_a, in_b, in_last,
    input  mul_product, mul_done, out_ready,
    output in_ready, mul_start, mul_a, mul_b,
    output out_valid, out_sum, out_sat, err_timeout
  );

  modport master (
    output in_valid, in_a, in_b, in_last,
    output mul_product, mul_done, out_ready,
    input  in_ready, mul_start, mul_a, mul_b,
    input  out_valid, out_sum, out_sat, err_timeout
  );

endinterface

// File: rtl/spm_mac_sequencer_sat_accumulator.sv
// Combinational saturating add of a signed product into the accumulator.
// The sum is formed one bit wider than the accumulator so overflow is visible.
module sat_accumulator
  import spm_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [PROD_W-1:0] prod_i,
  output logic signed [ACC_W-1:0]  acc_o,
  output logic                     sat_o
);

  localparam logic signed [ACC_W:0] MAX = (ACC_W+1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] MIN = (ACC_W+1)'(sat_min(ACC_W));

  logic signed [ACC_W:0] sum;

  always_comb begin
    sum   = (ACC_W+1)'(acc_i) + (ACC_W+1)'(prod_i);
    acc_o = sum[ACC_W-1:0];
    sat_o = 1'b0;
    if (sum > MAX) begin
      acc_o = MAX[ACC_W-1:0];
      sat_o = 1'b1;
    end else if (sum < MIN) begin
      acc_o = MIN[ACC_W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/spm_mac_sequencer.sv
// Dot-product frame engine: feeds operand pairs to the serial multiplier,
// accumulates products with saturation and emits one sum per frame.
module spm_mac_sequencer
  import spm_pkg::*;
#(
  parameter int ACC_W   = 24,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int TIMEOUT = 64
) (
  input logic      clk,
  input logic      rst,
  spm_mac_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAT_M1 = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] TO_M1  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  state_e state_q, state_d;

  logic [CW-1:0]            cnt_q;
  logic signed [OP_W-1:0]   a_q, b_q;
  logic                     last_q;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_q, acc_nx;
  logic                     sat_q, sat_nx;
  logic                     err_q;

  logic in_ready, mul_start, out_valid;
  logic xfer, done_ok, tmo;

  // A sticky done from the previous pair is only trusted once the
  // multiplier has had its full latency.
  assign xfer    = bus.in_valid && in_ready;
  assign done_ok = bus.mul_done && (cnt_q >= LAT_M1);
  assign tmo     = (cnt_q >= TO_M1) && !done_ok;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    mul_start = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (xfer) state_d = ISSUE;
      end
      ISSUE: begin
        mul_start = 1'b1;
        if (done_ok || tmo) state_d = ACCUM;
      end
      ACCUM:   state_d = RELEASE;
      RELEASE: state_d = last_q ? OUTPUT : IDLE;
      OUTPUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= 1'b0;
      prod_q  <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        a_q    <= bus.in_a;
        b_q    <= bus.in_b;
        last_q <= bus.in_last;
        cnt_q  <= '0;
      end
      if (state_q == ISSUE) begin
        if (cnt_q != TO_MAX) cnt_q <= cnt_q + CW'(1);
        if (done_ok) begin
          prod_q <= bus.mul_product;
        end else if (tmo) begin
          prod_q <= '0;
          err_q  <= 1'b1;
        end
      end
      if (state_q == ACCUM) begin
        acc_q <= acc_nx;
        sat_q <= sat_q | sat_nx;
      end
      if (state_q == OUTPUT && bus.out_ready) begin
        acc_q <= '0;
        sat_q <= 1'b0;
      end
    end
  end

  sat_accumulator #(.ACC_W(ACC_W)) u_sat (
    .acc_i  (acc_q),
    .prod_i (prod_q),
    .acc_o  (acc_nx),
    .sat_o  (sat_nx)
  );

  assign bus.in_ready    = in_ready;
  assign bus.mul_start   = mul_start;
  assign bus.mul_a       = a_q;
  assign bus.mul_b       = b_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_sum     = acc_q;
  assign bus.out_sat     = sat_q;
  assign bus.err_timeout = err_q;

endmodule
